// File: rtl/issue_scheduler_pkg.sv
// Shared types and constants for the issue scheduler and its CDB reservation register.
// The reservation slot positions encode each unit's fixed result latency.
package issue_scheduler_pkg;

    typedef enum logic [2:0] {
        CDB_EMPTY = 3'd0,
        CDB_INT   = 3'd1,
        CDB_MEM   = 3'd2,
        CDB_MULT  = 3'd3,
        CDB_DIV   = 3'd4
    } cdb_src_t;

    localparam int CDB_DEPTH   = 7;
    localparam int SLOT_INTMEM = 0;
    localparam int SLOT_MULT   = 3;
    localparam int SLOT_DIV    = 6;
    localparam int DIV_LAT     = 7;

    // Divider countdown starts one short of its latency so the next grant lands at t+DIV_LAT.
    localparam logic [2:0] DIV_CNT_LOAD = 3'(DIV_LAT - 1);

    function automatic logic slot_free(input cdb_src_t s);
        return (s == CDB_EMPTY);
    endfunction

endpackage

// File: rtl/issue_scheduler_cdb_rsv_shift.sv
// Reservation register: one entry per future CDB cycle, shifting toward the bus each clock.
// Grants claim slots after the shift; the scheduler guarantees only free slots are claimed.
module cdb_rsv_shift
    import issue_scheduler_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     wr_intmem,
    input  cdb_src_t intmem_src,
    input  logic     wr_mult,
    input  logic     wr_div,
    output cdb_src_t cdb_o,
    output cdb_src_t next_intmem_o,
    output cdb_src_t next_mult_o
);

    cdb_src_t [CDB_DEPTH-1:0] rsv_d;
    cdb_src_t [CDB_DEPTH-1:0] rsv_q;

    // Shift one slot toward the bus, then overlay this cycle's grants.
    always_comb begin
        rsv_d = {CDB_DEPTH{CDB_EMPTY}};
        for (int i = 0; i < CDB_DEPTH - 1; i++) begin
            rsv_d[i] = rsv_q[i+1];
        end
        rsv_d[SLOT_INTMEM] = wr_intmem ? intmem_src : rsv_q[SLOT_INTMEM+1];
        rsv_d[SLOT_MULT]   = wr_mult   ? CDB_MULT   : rsv_q[SLOT_MULT+1];
        rsv_d[SLOT_DIV]    = wr_div    ? CDB_DIV    : CDB_EMPTY;
    end

    // Reservation state, cleared asynchronously so no stale broadcast survives reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsv_q <= {CDB_DEPTH{CDB_EMPTY}};
        end else begin
            rsv_q <= rsv_d;
        end
    end

    assign cdb_o         = rsv_q[0];
    assign next_intmem_o = rsv_q[SLOT_INTMEM+1];
    assign next_mult_o   = rsv_q[SLOT_MULT+1];

endmodule

// File: rtl/issue_scheduler.sv
// Issue scheduler: grants int/mem/mult/div issue so that no two results collide on the CDB.
// Grants are combinational; CDB ownership, LRU and divider occupancy are registered.
module issue_scheduler
    import issue_scheduler_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       ready_int,
    input  logic       ready_mem,
    input  logic       ready_mult,
    input  logic       ready_div,
    input  logic       flush,
    output logic       issue_int,
    output logic       issue_mem,
    output logic       issue_mult,
    output logic       issue_div,
    output logic [2:0] cdb_sel,
    output logic       div_busy
);

    cdb_src_t   cdb_s;
    cdb_src_t   next_intmem_s;
    cdb_src_t   next_mult_s;
    cdb_src_t   intmem_src_s;
    logic       grant_en_s;
    logic       elig_int_s;
    logic       elig_mem_s;
    logic       lru_d;
    logic       lru_q;
    logic [2:0] div_cnt_d;
    logic [2:0] div_cnt_q;

    // Arbitration; lru_q low means int wins a tie. Reset also masks grants while held.
    always_comb begin
        grant_en_s   = rst & ~flush;
        elig_int_s   = grant_en_s & ready_int & slot_free(next_intmem_s);
        elig_mem_s   = grant_en_s & ready_mem & slot_free(next_intmem_s);
        issue_int    = elig_int_s & (~elig_mem_s | ~lru_q);
        issue_mem    = elig_mem_s & (~elig_int_s | lru_q);
        issue_mult   = grant_en_s & ready_mult & slot_free(next_mult_s);
        issue_div    = grant_en_s & ready_div & (div_cnt_q == 3'd0);
        intmem_src_s = issue_mem ? CDB_MEM : CDB_INT;
    end

    // Next-state for LRU and divider countdown.
    always_comb begin
        lru_d     = issue_int ? 1'b1 : (issue_mem ? 1'b0 : lru_q);
        div_cnt_d = issue_div ? DIV_CNT_LOAD
                  : ((div_cnt_q != 3'd0) ? (div_cnt_q - 3'd1) : 3'd0);
    end

    // LRU and divider occupancy state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lru_q     <= 1'b0;
            div_cnt_q <= 3'd0;
        end else begin
            lru_q     <= lru_d;
            div_cnt_q <= div_cnt_d;
        end
    end

    cdb_rsv_shift u_rsv (
        .clk           (clk),
        .rst           (rst),
        .wr_intmem     (issue_int | issue_mem),
        .intmem_src    (intmem_src_s),
        .wr_mult       (issue_mult),
        .wr_div        (issue_div),
        .cdb_o         (cdb_s),
        .next_intmem_o (next_intmem_s),
        .next_mult_o   (next_mult_s)
    );

    assign cdb_sel  = cdb_s;
    assign div_busy = (div_cnt_q != 3'd0);

endmodule

// File: tb/tb_issue_scheduler.sv
// Directed bench for issue_scheduler: each step drives one cycle and checks grants, CDB owner, div_busy.
// Cycle 0 is the first clock period after reset release; inputs change 1 ns after the rising edge.
module tb_issue_scheduler;

    logic       clk;
    logic       rst;
    logic       ready_int;
    logic       ready_mem;
    logic       ready_mult;
    logic       ready_div;
    logic       flush;
    logic       issue_int;
    logic       issue_mem;
    logic       issue_mult;
    logic       issue_div;
    logic [2:0] cdb_sel;
    logic       div_busy;

    int errors = 0;
    int checks = 0;

    issue_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .ready_int  (ready_int),
        .ready_mem  (ready_mem),
        .ready_mult (ready_mult),
        .ready_div  (ready_div),
        .flush      (flush),
        .issue_int  (issue_int),
        .issue_mem  (issue_mem),
        .issue_mult (issue_mult),
        .issue_div  (issue_div),
        .cdb_sel    (cdb_sel),
        .div_busy   (div_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // in = {ready_int, ready_mem, ready_mult, ready_div, flush}; e_iss = {int, mem, mult, div}
    task automatic cyc(input string tag, input logic [4:0] in, input logic [3:0] e_iss,
                       input logic [2:0] e_cdb, input logic e_busy, input bit ck_busy);
        @(posedge clk);
        #1;
        {ready_int, ready_mem, ready_mult, ready_div, flush} = in;
        @(negedge clk);
        chk({tag, "/iss"}, {issue_int, issue_mem, issue_mult, issue_div}, e_iss);
        chk({tag, "/cdb"}, {1'b0, cdb_sel}, {1'b0, e_cdb});
        if (ck_busy) chk({tag, "/busy"}, {3'b000, div_busy}, {3'b000, e_busy});
    endtask

    task automatic do_reset();
        rst = 1'b0;
        {ready_int, ready_mem, ready_mult, ready_div, flush} = 5'b00000;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        {ready_int, ready_mem, ready_mult, ready_div, flush} = 5'b00000;

        // A: int alone every cycle, result one cycle later
        do_reset();
        cyc("A0", 5'b10000, 4'b1000, 3'd0, 1'b0, 1'b1);
        cyc("A1", 5'b10000, 4'b1000, 3'd1, 1'b0, 1'b1);
        cyc("A2", 5'b10000, 4'b1000, 3'd1, 1'b0, 1'b1);
        cyc("A3", 5'b10000, 4'b1000, 3'd1, 1'b0, 1'b1);

        // B: int/mem LRU alternation starting from int after reset
        do_reset();
        cyc("B0", 5'b11000, 4'b1000, 3'd0, 1'b0, 1'b1);
        cyc("B1", 5'b11000, 4'b0100, 3'd1, 1'b0, 1'b1);
        cyc("B2", 5'b11000, 4'b1000, 3'd2, 1'b0, 1'b1);
        cyc("B3", 5'b11000, 4'b0100, 3'd1, 1'b0, 1'b1);
        cyc("B4", 5'b00000, 4'b0000, 3'd2, 1'b0, 1'b1);
        cyc("B5", 5'b00000, 4'b0000, 3'd0, 1'b0, 1'b1);

        // C: mult granted at t5 owns CDB at t9, so int is blocked at t8
        do_reset();
        cyc("C0",  5'b10000, 4'b1000, 3'd0, 1'b0, 1'b1);
        cyc("C1",  5'b10000, 4'b1000, 3'd1, 1'b0, 1'b1);
        cyc("C2",  5'b10000, 4'b1000, 3'd1, 1'b0, 1'b1);
        cyc("C3",  5'b10000, 4'b1000, 3'd1, 1'b0, 1'b1);
        cyc("C4",  5'b10000, 4'b1000, 3'd1, 1'b0, 1'b1);
        cyc("C5",  5'b10100, 4'b1010, 3'd1, 1'b0, 1'b1);
        cyc("C6",  5'b10000, 4'b1000, 3'd1, 1'b0, 1'b1);
        cyc("C7",  5'b10000, 4'b1000, 3'd1, 1'b0, 1'b1);
        cyc("C8",  5'b10000, 4'b0000, 3'd1, 1'b0, 1'b1);
        cyc("C9",  5'b10000, 4'b1000, 3'd3, 1'b0, 1'b1);
        cyc("C10", 5'b10000, 4'b1000, 3'd1, 1'b0, 1'b1);

        // D: div every 7 cycles; in-flight div blocks mult at t3, mult lands at t8
        do_reset();
        cyc("D0",  5'b00010, 4'b0001, 3'd0, 1'b0, 1'b1);
        cyc("D1",  5'b00010, 4'b0000, 3'd0, 1'b1, 1'b1);
        cyc("D2",  5'b00010, 4'b0000, 3'd0, 1'b1, 1'b1);
        cyc("D3",  5'b00110, 4'b0000, 3'd0, 1'b1, 1'b1);
        cyc("D4",  5'b00110, 4'b0010, 3'd0, 1'b1, 1'b1);
        cyc("D5",  5'b00010, 4'b0000, 3'd0, 1'b1, 1'b1);
        cyc("D6",  5'b00010, 4'b0000, 3'd0, 1'b1, 1'b1);
        cyc("D7",  5'b00010, 4'b0001, 3'd4, 1'b0, 1'b1);
        cyc("D8",  5'b00010, 4'b0000, 3'd3, 1'b1, 1'b1);
        cyc("D9",  5'b00010, 4'b0000, 3'd0, 1'b1, 1'b1);
        cyc("D10", 5'b00010, 4'b0000, 3'd0, 1'b1, 1'b1);
        cyc("D11", 5'b00010, 4'b0000, 3'd0, 1'b1, 1'b1);
        cyc("D12", 5'b00010, 4'b0000, 3'd0, 1'b1, 1'b1);
        cyc("D13", 5'b00010, 4'b0000, 3'd0, 1'b1, 1'b1);
        cyc("D14", 5'b00010, 4'b0001, 3'd4, 1'b0, 1'b1);
        cyc("D15", 5'b00010, 4'b0000, 3'd0, 1'b1, 1'b1);

        // E: all ready, flush at t3 suppresses grants; queued results keep draining
        do_reset();
        cyc("E0", 5'b11110, 4'b1011, 3'd0, 1'b0, 1'b1);
        cyc("E1", 5'b11110, 4'b0110, 3'd1, 1'b1, 1'b1);
        cyc("E2", 5'b11110, 4'b1010, 3'd2, 1'b1, 1'b1);
        cyc("E3", 5'b11111, 4'b0000, 3'd1, 1'b1, 1'b1);
        cyc("E4", 5'b00000, 4'b0000, 3'd3, 1'b1, 1'b1);
        cyc("E5", 5'b00000, 4'b0000, 3'd3, 1'b0, 1'b0);
        cyc("E6", 5'b00000, 4'b0000, 3'd3, 1'b0, 1'b0);
        cyc("E7", 5'b00000, 4'b0000, 3'd4, 1'b0, 1'b0);
        cyc("E8", 5'b00000, 4'b0000, 3'd0, 1'b0, 1'b0);

        // F: asynchronous reset mid-cycle with reservations in flight
        do_reset();
        cyc("F0", 5'b11110, 4'b1011, 3'd0, 1'b0, 1'b1);
        cyc("F1", 5'b11110, 4'b0110, 3'd1, 1'b1, 1'b1);
        cyc("F2", 5'b11110, 4'b1010, 3'd2, 1'b1, 1'b1);
        cyc("F3", 5'b00000, 4'b0000, 3'd1, 1'b1, 1'b1);
        #2;
        {ready_int, ready_mem, ready_mult, ready_div, flush} = 5'b11110;
        rst = 1'b0;
        #1;
        chk("Frst/iss", {issue_int, issue_mem, issue_mult, issue_div}, 4'b0000);
        chk("Frst/cdb", {1'b0, cdb_sel}, 4'd0);
        chk("Frst/busy", {3'b000, div_busy}, 4'd0);
        @(posedge clk);
        @(negedge clk);
        {ready_int, ready_mem, ready_mult, ready_div, flush} = 5'b00000;
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc($sformatf("Fidle%0d", i), 5'b00000, 4'b0000, 3'd0, 1'b0, 1'b1);
        end
        cyc("Fg0", 5'b10000, 4'b1000, 3'd0, 1'b0, 1'b1);
        cyc("Fg1", 5'b00000, 4'b0000, 3'd1, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
